// File: rtl/stfft_frame_sched.sv
// rtl/stfft_frame_sched.sv - overlapped STFFT frame scheduler over a 2*FFT_SIZE circular sample buffer
module stfft_frame_sched #(
    parameter int IW     = 16,
    parameter int LGNFFT = 8,
    parameter int LGHOP  = 7
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic [IW-1:0] i_sample,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [IW-1:0] o_sample,
    output logic          o_frame,
    output logic          o_last,
    output logic          o_busy,
    output logic          o_overrun
);

    localparam int FFT_SIZE = 1 << LGNFFT;
    localparam int HOP_SIZE = 1 << LGHOP;
    localparam int AW       = LGNFFT + 1;
    localparam int HW       = LGHOP + 1;

    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [AW-1:0] N_A      = AW'(FFT_SIZE);
    localparam logic [AW-1:0] LAST_A   = AW'(FFT_SIZE - 1);
    localparam logic [HW-1:0] ONE_H    = HW'(1);
    localparam logic [HW-1:0] HOP_LAST = HW'(HOP_SIZE - 1);

    localparam logic [1:0] S_FILL   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [IW-1:0] mem [0:2*FFT_SIZE-1];

    logic [1:0]    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] fill_cnt;
    logic [HW-1:0] hop_cnt;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] iss_cnt;
    logic [AW-1:0] rd_addr;

    logic          rd_valid;
    logic          rd_first;
    logic          rd_last;
    logic [IW-1:0] rd_data;

    logic trig;
    logic last_xfer;
    logic start;
    logic out_adv;
    logic s1_adv;
    logic issue;

    always_comb begin
        trig = 1'b0;
        if (state == S_FILL)
            trig = i_ce && (fill_cnt == LAST_A);
        else
            trig = i_ce && (hop_cnt == HOP_LAST);
        last_xfer = o_valid && i_ready && o_last;
        // A trigger only starts a frame if the previous one is finishing this very cycle
        start     = trig && ((state != S_STREAM) || last_xfer);
        out_adv   = !o_valid || i_ready;
        s1_adv    = !rd_valid || out_adv;
        issue     = (state == S_STREAM) && (iss_cnt != N_A) && s1_adv;
        rd_addr   = rd_base + iss_cnt;
    end

    assign o_busy = (state == S_STREAM);

    always_ff @(posedge i_clk) begin
        if (i_ce)
            mem[wr_ptr] <= i_sample;
        if (issue)
            rd_data <= mem[rd_addr];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= S_FILL;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            hop_cnt   <= '0;
            rd_base   <= '0;
            iss_cnt   <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (i_ce) begin
                wr_ptr <= wr_ptr + ONE_A;
                if (state == S_FILL)
                    fill_cnt <= fill_cnt + ONE_A;
                else if (hop_cnt == HOP_LAST)
                    hop_cnt <= '0;
                else
                    hop_cnt <= hop_cnt + ONE_H;
            end
            if (start) begin
                state   <= S_STREAM;
                // The newest FFT_SIZE samples end at the slot just written; -N equals +N mod 2N
                rd_base <= wr_ptr + ONE_A + N_A;
                iss_cnt <= '0;
            end else begin
                if (last_xfer)
                    state <= S_IDLE;
                if (issue)
                    iss_cnt <= iss_cnt + ONE_A;
            end
            if (trig && !start)
                o_overrun <= 1'b1;
        end
    end

    // Two-stage read pipeline: RAM output register, then the output register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_valid <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
            o_valid  <= 1'b0;
            o_sample <= '0;
            o_frame  <= 1'b0;
            o_last   <= 1'b0;
        end else begin
            if (s1_adv) begin
                rd_valid <= issue;
                if (issue) begin
                    rd_first <= (iss_cnt == '0);
                    rd_last  <= (iss_cnt == LAST_A);
                end
            end
            if (out_adv) begin
                o_valid  <= rd_valid;
                o_sample <= rd_data;
                o_frame  <= rd_valid && rd_first;
                o_last   <= rd_valid && rd_last;
            end
        end
    end

endmodule
